dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: port A (CPU load/store stage) and port B (debug/DMA loader).
- Round-robin arbitration, with an optional per-port lock for back-to-back bursts.
- Drives the memory's enable/write/address/data pins and returns read data to the winning port one cycle later.
- Sits between the pipeline's memory stage and the data memory array.

Parameters:
AW  6   word-address width (memory depth = 2**AW words)
DW  32  data width

Ports:
CLK        in   1   clock, all state updates on posedge
RST        in   1   synchronous, active-high reset
REQ_A      in   1   port A request
WE_A       in   1   port A write (1) / read (0)
LOCK_A     in   1   port A keeps ownership after this access
ADR_A      in   32  port A byte address
WDATA_A    in   DW  port A write data
GNT_A      out  1   port A access accepted this cycle
RVALID_A   out  1   port A read data valid
RDATA_A    out  DW  port A read data
REQ_B, WE_B, LOCK_B, ADR_B, WDATA_B, GNT_B, RVALID_B, RDATA_B: same as port A, for port B
MEM_EN     out  1   memory access this cycle
MEM_WE     out  1   memory write strobe
MEM_ADR    out  AW  memory word address
MEM_WDATA  out  DW  memory write data
MEM_RDATA  in   DW  memory read data, valid the cycle after MEM_EN with MEM_WE=0

Behaviour:
- Word address = ADR_x[AW+1:2]. ADR_x[1:0] and ADR_x[31:AW+2] are ignored (no fault).
- GNT_x is combinational from REQ_x and the registered state. At most one GNT per cycle. A request counts as accepted only in a cycle where GNT_x=1. A requester holds REQ/WE/ADR/WDATA stable until granted.
- On a grant, in the same cycle: MEM_EN=1, MEM_WE=WE_x, MEM_ADR=word address, MEM_WDATA=WDATA_x. With no grant: MEM_EN=0, MEM_WE=0, MEM_ADR=0, MEM_WDATA=0.
- Read latency: one cycle.
  - A granted read in cycle N sets RVALID_x=1 in cycle N+1.
  - RDATA_x=MEM_RDATA in that cycle (pass-through, no extra register).
  - RVALID_x is a 1-cycle pulse. Writes produce no RVALID.
  - RDATA_x is 0 whenever RVALID_x=0.
- Registered state: owner FSM {IDLE, OWN_A, OWN_B}, priority pointer PRI (0=A first, 1=B first), pending-read tags RD_A and RD_B.
- IDLE:
  - Only one REQ asserted: grant that port.
  - Both asserted: grant the port selected by PRI.
  - After any grant, PRI points to the other port.
  - Granted port with LOCK_x=1: next state OWN_x. Otherwise stay IDLE.
- OWN_A: only port A may be granted; GNT_B=0 regardless of REQ_B.
  - Grant with LOCK_A=1: stay OWN_A.
  - Grant with LOCK_A=0: go to IDLE.
  - REQ_A=0: stay OWN_A (ownership held, no timeout).
- OWN_B: symmetric to OWN_A.
- PRI updates only on grants made from IDLE. Lock bursts do not advance it.
- Reset:
  - State=IDLE, PRI=0, RD_A=RD_B=0.
  - All outputs 0 in the reset cycle.
  - A read granted in the cycle before RST is asserted produces no RVALID.
  - Reset mid-lock releases ownership.

Test Plan:
- Single read: reset, REQ_A=1, WE_A=0, ADR_A=0x10 -> same cycle GNT_A=1, MEM_EN=1, MEM_WE=0, MEM_ADR=4. Next cycle RVALID_A=1, RDATA_A=MEM_RDATA (model returns 0xDEADBEEF). GNT_B=0 and RVALID_B=0 throughout.
- Contention round-robin: REQ_A=REQ_B=1 (reads at 0x0 and 0x4) for 4 cycles after reset -> grants A, B, A, B. RVALID alternates one cycle later, data matches memory model words 0 and 1.
- Write then read: B writes 0x12345678 to ADR_B=0xFC -> MEM_WE=1, MEM_ADR=63. B then reads 0xFC -> RDATA_B=0x12345678. Word-address wrap check: ADR_B=0x100 -> MEM_ADR=0.
- Lock burst: A issues 3 reads with LOCK_A=1,1,0 while REQ_B=1 throughout -> GNT_B=0 for those 3 grants, then B is granted in the next cycle. PRI unchanged by the burst.
- Lock hold idle: A locks, then drops REQ_A for 5 cycles while REQ_B=1 -> GNT_B stays 0 and MEM_EN=0. B is granted only after A's next grant with LOCK_A=0.
- Reset mid-operation: A read granted, RST=1 next cycle -> RVALID_A=0 and all outputs 0. After RST deasserts with REQ_A=REQ_B=1 -> A granted first (PRI=0).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// memory stage (port A) and the debug/DMA loader (port B), with per-port lock.
module dmem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_A,
  input  logic          WE_A,
  input  logic          LOCK_A,
  input  logic [31:0]   ADR_A,
  input  logic [DW-1:0] WDATA_A,
  output logic          GNT_A,
  output logic          RVALID_A,
  output logic [DW-1:0] RDATA_A,
  input  logic          REQ_B,
  input  logic          WE_B,
  input  logic          LOCK_B,
  input  logic [31:0]   ADR_B,
  input  logic [DW-1:0] WDATA_B,
  output logic          GNT_B,
  output logic          RVALID_B,
  output logic [DW-1:0] RDATA_B,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t state;
  logic   pri;   // 0: A wins a tie, 1: B wins a tie
  logic   rd_a;
  logic   rd_b;
  logic   gnt_a;
  logic   gnt_b;

  // Byte-offset and high address bits are deliberately dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{ADR_A[31:AW+2], ADR_A[1:0], ADR_B[31:AW+2], ADR_B[1:0]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          gnt_a = REQ_A & (~REQ_B | ~pri);
          gnt_b = REQ_B & (~REQ_A |  pri);
        end
        OWN_A:   gnt_a = REQ_A;
        OWN_B:   gnt_b = REQ_B;
        default: ;
      endcase
    end
  end

  assign GNT_A = gnt_a;
  assign GNT_B = gnt_b;

  always_comb begin
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADR   = '0;
    MEM_WDATA = '0;
    if (gnt_a) begin
      MEM_EN    = 1'b1;
      MEM_WE    = WE_A;
      MEM_ADR   = ADR_A[AW+1:2];
      MEM_WDATA = WDATA_A;
    end else if (gnt_b) begin
      MEM_EN    = 1'b1;
      MEM_WE    = WE_B;
      MEM_ADR   = ADR_B[AW+1:2];
      MEM_WDATA = WDATA_B;
    end
  end

  // Read tags are masked during reset so a read granted just before RST
  // never surfaces.
  assign RVALID_A = rd_a & ~RST;
  assign RVALID_B = rd_b & ~RST;
  assign RDATA_A  = RVALID_A ? MEM_RDATA : '0;
  assign RDATA_B  = RVALID_B ? MEM_RDATA : '0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pri   <= 1'b0;
      rd_a  <= 1'b0;
      rd_b  <= 1'b0;
    end else begin
      rd_a <= gnt_a & ~WE_A;
      rd_b <= gnt_b & ~WE_B;

      // Lock bursts leave the priority pointer untouched.
      if (state == IDLE) begin
        if (gnt_a)      pri <= 1'b1;
        else if (gnt_b) pri <= 1'b0;
      end

      if (gnt_a)      state <= LOCK_A ? OWN_A : IDLE;
      else if (gnt_b) state <= LOCK_B ? OWN_B : IDLE;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// synchronous-read memory behind the arbiter.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, we_a, lock_a, req_b, we_b, lock_b;
  logic [31:0]   adr_a, adr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(clk), .RST(rst),
    .REQ_A(req_a), .WE_A(we_a), .LOCK_A(lock_a), .ADR_A(adr_a), .WDATA_A(wdata_a),
    .GNT_A(gnt_a), .RVALID_A(rvalid_a), .RDATA_A(rdata_a),
    .REQ_B(req_b), .WE_B(we_b), .LOCK_B(lock_b), .ADR_B(adr_b), .WDATA_B(wdata_b),
    .GNT_B(gnt_b), .RVALID_B(rvalid_b), .RDATA_B(rdata_b),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADR(mem_adr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_adr] <= mem_wdata;
      else        mem_rdata    <= mem[mem_adr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_a = 0; we_a = 0; lock_a = 0; adr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; lock_b = 0; adr_b = '0; wdata_b = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[4] = 32'hDEAD_BEEF;
    idle_inputs();

    // Reset cycle: outputs stay 0 even with requests present.
    rst = 1; req_a = 1; adr_a = 32'h10; req_b = 1;
    sample();
    check("rst_ctrl", {gnt_a, gnt_b, mem_en, mem_we, rvalid_a, rvalid_b}, 0);
    check("rst_adr", mem_adr, 0);
    tick();

    // Single read from A.
    rst = 0; req_b = 0;
    sample();
    check("rd_gnt_a", gnt_a, 1);
    check("rd_gnt_b", gnt_b, 0);
    check("rd_en_we", {mem_en, mem_we}, 2'b10);
    check("rd_adr", mem_adr, 4);
    tick();
    req_a = 0;
    sample();
    check("rd_rvalid_a", rvalid_a, 1);
    check("rd_rdata_a", rdata_a, 32'hDEAD_BEEF);
    check("rd_rvalid_b", rvalid_b, 0);
    check("rd_idle_en", {gnt_a, gnt_b, mem_en}, 0);
    tick();
    sample();
    check("rd_pulse", rvalid_a, 0);
    check("rd_rdata_zero", rdata_a, 0);
    tick();

    // Contention: both read continuously, grants alternate A, B, A, B.
    do_reset();
    req_a = 1; adr_a = 32'h0; req_b = 1; adr_b = 32'h4;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("rr_gnt_a", gnt_a, (k % 2 == 0) ? 1 : 0);
      check("rr_gnt_b", gnt_b, (k % 2 == 1) ? 1 : 0);
      if (k > 0) begin
        check("rr_rvalid_a", rvalid_a, ((k - 1) % 2 == 0) ? 1 : 0);
        check("rr_rdata_a", rdata_a, ((k - 1) % 2 == 0) ? 32'hC0DE_0000 : 32'h0);
        check("rr_rdata_b", rdata_b, ((k - 1) % 2 == 1) ? 32'hC0DE_0001 : 32'h0);
      end
      tick();
    end
    req_a = 0; req_b = 0;
    sample();
    check("rr_last_valid", {rvalid_a, rvalid_b}, 2'b01);
    check("rr_last_data", rdata_b, 32'hC0DE_0001);
    tick();

    // Write then read back at the top word, then address wrap.
    req_b = 1; we_b = 1; adr_b = 32'hFC; wdata_b = 32'h1234_5678;
    sample();
    check("wr_gnt_b", gnt_b, 1);
    check("wr_we", mem_we, 1);
    check("wr_adr", mem_adr, 63);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    tick();
    we_b = 0;
    sample();
    check("rb_gnt_b", gnt_b, 1);
    check("rb_we", mem_we, 0);
    check("wr_no_rvalid", rvalid_b, 0);
    tick();
    adr_b = 32'h100;
    sample();
    check("rb_rvalid_b", rvalid_b, 1);
    check("rb_rdata_b", rdata_b, 32'h1234_5678);
    check("wrap_adr", mem_adr, 0);
    tick();
    req_b = 0; wdata_b = 32'hFFFF_FFFF;
    sample();
    check("idle_wdata", mem_wdata, 0);
    check("idle_en", mem_en, 0);
    check("wrap_rdata", rdata_b, 32'hC0DE_0000);
    tick();
    wdata_b = '0;

    // Lock burst of 3 grants for A while B waits.
    do_reset();
    req_a = 1; adr_a = 32'hC; req_b = 1; adr_b = 32'h8;
    for (int k = 0; k < 3; k++) begin
      lock_a = (k < 2);
      sample();
      check("lk_gnt_a", gnt_a, 1);
      check("lk_gnt_b", gnt_b, 0);
      check("lk_adr", mem_adr, 3);
      tick();
    end
    sample();
    check("lk_after_b", {gnt_a, gnt_b}, 2'b01);
    check("lk_after_adr", mem_adr, 2);
    tick();
    sample();
    check("lk_next_a", {gnt_a, gnt_b}, 2'b10);
    tick();

    // Two-grant burst: a burst that advanced PRI would hand A the tie.
    do_reset();
    req_a = 1; req_b = 1; lock_a = 1;
    sample();
    check("lk2_first", {gnt_a, gnt_b}, 2'b10);
    tick();
    lock_a = 0;
    sample();
    check("lk2_second", {gnt_a, gnt_b}, 2'b10);
    tick();
    sample();
    check("lk2_pri", {gnt_a, gnt_b}, 2'b01);
    tick();

    // Lock held while A is idle: B starved until A releases.
    do_reset();
    req_a = 1; lock_a = 1;
    sample();
    check("hold_lock", gnt_a, 1);
    tick();
    req_a = 0; req_b = 1;
    for (int k = 0; k < 5; k++) begin
      sample();
      check("hold_gnt_b", gnt_b, 0);
      check("hold_en", mem_en, 0);
      tick();
    end
    req_a = 1; lock_a = 0;
    sample();
    check("hold_release", {gnt_a, gnt_b}, 2'b10);
    tick();
    req_a = 0;
    sample();
    check("hold_b_gnt", gnt_b, 1);
    tick();

    // Reset right after a granted read suppresses its RVALID.
    do_reset();
    req_a = 1; adr_a = 32'h10;
    sample();
    check("mid_gnt", gnt_a, 1);
    tick();
    rst = 1; req_b = 1;
    sample();
    check("mid_rvalid", rvalid_a, 0);
    check("mid_rdata", rdata_a, 0);
    check("mid_outs", {gnt_a, gnt_b, mem_en}, 0);
    tick();
    rst = 0;
    sample();
    check("mid_pri", {gnt_a, gnt_b}, 2'b10);
    check("mid_no_stale", rvalid_a, 0);
    tick();

    // Reset while A owns the memory releases the lock.
    req_b = 0; lock_a = 1;
    sample();
    check("rl_lock", gnt_a, 1);
    tick();
    rst = 1; req_a = 0; lock_a = 0; req_b = 1;
    tick();
    rst = 0;
    sample();
    check("rl_b_gnt", gnt_b, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
